// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - shares the VGA pixel-write port among drawing engines with burst grants
// Optional ROUND_ROBIN_EN selects rotating priority; default is fixed priority (index 0 highest).
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int TIMEOUT  = 19200,
  parameter int TO_W     = 15
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           done,
  input  logic [NUM_REQ-1:0]           px_valid,
  input  logic [NUM_REQ*X_W-1:0]       x_in,
  input  logic [NUM_REQ*Y_W-1:0]       y_in,
  input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t               state, state_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [IDX_W-1:0]     sel, sel_d;
  logic [IDX_W-1:0]     win;
  logic [TO_W-1:0]      cnt, cnt_d;
  logic [X_W-1:0]       x_d;
  logic [Y_W-1:0]       y_d;
  logic [COLOUR_W-1:0]  colour_d;
  logic                 plot_d;
  logic                 terr_d;
  logic                 last_cycle;
  logic                 owner_leaves;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]     ptr, ptr_d;

  // Scan downward and overwrite so the survivor is the first hit upward from ptr.
  always_comb begin
    win = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) win = IDX_W'((int'(ptr) + k) % NUM_REQ);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) win = IDX_W'(i);
    end
  end
`endif

  assign last_cycle   = (cnt == TO_W'(TIMEOUT - 1));
  assign owner_leaves = done[sel] || !req[sel];
  assign busy         = (state == S_GRANT);

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    sel_d    = sel;
    cnt_d    = cnt;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;
    terr_d   = 1'b0;
`ifdef ROUND_ROBIN_EN
    ptr_d    = ptr;
`endif
    case (state)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        cnt_d = '0;
        if (|req) begin
          grant_d = NUM_REQ'(1) << win;
          sel_d   = win;
          state_d = S_GRANT;
`ifdef ROUND_ROBIN_EN
          ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // The owner's pixel is written even on the cycle the burst ends.
        plot_d = px_valid[sel];
        if (px_valid[sel]) begin
          x_d      = x_in[sel*X_W +: X_W];
          y_d      = y_in[sel*Y_W +: Y_W];
          colour_d = colour_in[sel*COLOUR_W +: COLOUR_W];
        end
        if (!last_cycle) cnt_d = cnt + 1'b1;
        if (owner_leaves) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end else if (last_cycle) begin
          grant_d = '0;
          terr_d  = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      grant       <= '0;
      sel         <= '0;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr         <= '0;
`endif
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      sel         <= sel_d;
      cnt         <= cnt_d;
      x           <= x_d;
      y           <= y_d;
      colour      <= colour_d;
      plot        <= plot_d;
      timeout_err <= terr_d;
`ifdef ROUND_ROBIN_EN
      ptr         <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - self-checking bench for vga_plot_arbiter against a behavioural model
module tb_vga_plot_arbiter;

  localparam int N   = 4;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 3;
  localparam int TMO = 16;
  localparam int TOW = 5;

  localparam int P_FREE   = 0;
  localparam int P_DECIDE = 1;
  localparam int P_OWNED  = 2;
  localparam int P_GAP    = 3;

  logic            Clock;
  logic            rst_n;
  logic [N-1:0]    req, done, pxv;
  logic [N*XW-1:0] xin;
  logic [N*YW-1:0] yin;
  logic [N*CW-1:0] cin;
  logic [N-1:0]    grant;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;
  logic            plot, busy, timeout_err;

  logic [N-1:0]    e_grant;
  logic [XW-1:0]   e_x;
  logic [YW-1:0]   e_y;
  logic [CW-1:0]   e_col;
  logic            e_plot, e_busy, e_terr;

  int m_phase, m_owner, m_ptr, m_held;
  int n_tests, n_fail;

  wire [24:0] act_vec = {grant, x, y, colour, plot, busy, timeout_err};
  wire [24:0] exp_vec = {e_grant, e_x, e_y, e_col, e_plot, e_busy, e_terr};

  vga_plot_arbiter #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .TIMEOUT(TMO), .TO_W(TOW)
  ) dut (
    .Clock(Clock), .Resetn(rst_n), .req(req), .done(done), .px_valid(pxv),
    .x_in(xin), .y_in(yin), .colour_in(cin), .grant(grant), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .timeout_err(timeout_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Predicts the outputs that follow the coming edge from the inputs presented to it.
  task automatic model_step();
    int w;
    e_terr = 1'b0;
    if (!rst_n) begin
      e_grant = '0; e_x = '0; e_y = '0; e_col = '0; e_plot = 1'b0;
      m_phase = P_FREE; m_owner = -1; m_ptr = 0; m_held = 0;
    end else begin
      e_plot = 1'b0;
      case (m_phase)
        P_FREE:   if (req != 0) m_phase = P_DECIDE;
        P_DECIDE: begin
          if (req == 0) m_phase = P_FREE;
          else begin
            w = -1;
            for (int k = 0; k < N; k++)
              if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_owner = w;
            m_held  = 0;
            e_grant = '0;
            e_grant[w] = 1'b1;
`ifdef ROUND_ROBIN_EN
            m_ptr = (w + 1) % N;
`endif
            m_phase = P_OWNED;
          end
        end
        P_OWNED: begin
          m_held++;
          e_plot = pxv[m_owner];
          if (pxv[m_owner]) begin
            e_x   = xin[m_owner*XW +: XW];
            e_y   = yin[m_owner*YW +: YW];
            e_col = cin[m_owner*CW +: CW];
          end
          if (done[m_owner] || !req[m_owner]) begin
            e_grant = '0; m_phase = P_GAP;
          end else if (m_held == TMO) begin
            e_grant = '0; m_phase = P_GAP; e_terr = 1'b1;
          end
        end
        default:  m_phase = P_FREE;
      endcase
    end
    e_busy = (m_phase == P_OWNED);
  endtask

  task automatic step();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_px(input int i, input int xv, input int yv, input int cv);
    xin[i*XW +: XW] = XW'(xv);
    yin[i*YW +: YW] = YW'(yv);
    cin[i*CW +: CW] = CW'(cv);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = '0; pxv = '0; xin = '0; yin = '0; cin = '0;
    repeat (2) step();
    n_tests++;
    if ({grant, plot, busy, x, y, timeout_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", {grant, plot, busy, x, y, timeout_err});
    end
    n_tests++;
    if (act_vec !== exp_vec) begin
      n_fail++; $display("FAIL reset_model got=%h exp=%h", act_vec, exp_vec);
    end
    rst_n = 1'b1; req = '0;
    step();
  endtask

  task automatic test_single();
    req = 4'b0100;
    step();
    n_tests++;
    if (grant !== 4'b0000) begin
      n_fail++; $display("FAIL single_arb_cycle got=%b exp=0000", grant);
    end
    step();
    n_tests++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant got=%b/%b exp=0100/1", grant, busy);
    end
    pxv = 4'b0100; set_px(2, 5, 7, 5);
    step();
    n_tests++;
    if ({x, y, colour, plot} !== {8'd5, 7'd7, 3'd5, 1'b1}) begin
      n_fail++; $display("FAIL single_pixel got=%0d,%0d,%0d,%b exp=5,7,5,1", x, y, colour, plot);
    end
    pxv = '0; done = 4'b0100;
    step();
    n_tests++;
    if (grant !== 4'b0000) begin
      n_fail++; $display("FAIL single_done got=%b exp=0000", grant);
    end
    n_tests++;
    if (act_vec !== exp_vec) begin
      n_fail++; $display("FAIL single_model got=%h exp=%h", act_vec, exp_vec);
    end
    done = '0; req = '0;
    repeat (2) step();
  endtask

  task automatic test_contention();
    logic [N-1:0] prev;
    logic [N-1:0] seq[$];
    logic [N-1:0] want[3];
    int pix, dead_bad;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 4'b1010; pix = 0; prev = '0; dead_bad = 0;
    for (int c = 0; c < 60; c++) begin
      pxv = '0; done = '0;
      xin = $urandom; yin = 28'($urandom); cin = 12'($urandom);
      if (e_grant != 0) begin
        if (pix < 3) begin pxv = e_grant; pix++; end
        else begin done = e_grant; pix = 0; end
      end
      step();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL contention_model cyc%0d got=%h exp=%h", c, act_vec, exp_vec);
      end
      if (grant != 0 && grant != prev) seq.push_back(grant);
      if (prev != 0 && grant != 0 && grant != prev) dead_bad++;
      prev = grant;
    end
`ifdef ROUND_ROBIN_EN
    want[0] = 4'b0010; want[1] = 4'b1000; want[2] = 4'b0010;
`else
    want[0] = 4'b0010; want[1] = 4'b0010; want[2] = 4'b0010;
`endif
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (seq.size() <= i || seq[i] !== want[i]) begin
        n_fail++; $display("FAIL contention_order burst%0d got=%b exp=%b", i,
                           (seq.size() > i) ? seq[i] : 4'bxxxx, want[i]);
      end
    end
    n_tests++;
    if (dead_bad != 0) begin
      n_fail++; $display("FAIL contention_dead_cycle got=%0d exp=0", dead_bad);
    end
    req = '0; pxv = '0; done = '0;
    repeat (4) step();
  endtask

  task automatic test_timeout();
    int stage, run1, gap, terr_cnt, terr_at_drop;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 4'b0001; stage = 0; run1 = 0; gap = 0; terr_cnt = 0; terr_at_drop = 0;
    for (int c = 0; c < 40; c++) begin
      pxv = 4'($urandom); xin = $urandom; yin = 28'($urandom); cin = 12'($urandom);
      step();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL timeout_model cyc%0d got=%h exp=%h", c, act_vec, exp_vec);
      end
      if (stage < 3 && timeout_err) terr_cnt++;
      case (stage)
        0: if (grant == 4'b0001) begin stage = 1; run1 = 1; end
        1: if (grant == 4'b0001) run1++;
           else begin stage = 2; gap = 1; terr_at_drop = timeout_err; end
        2: if (grant == 4'b0000) gap++; else stage = 3;
        default: ;
      endcase
    end
    n_tests++;
    if (run1 != TMO) begin
      n_fail++; $display("FAIL timeout_hold got=%0d exp=%0d", run1, TMO);
    end
    n_tests++;
    if (terr_cnt != 1 || terr_at_drop != 1) begin
      n_fail++; $display("FAIL timeout_err_pulse got=%0d/%0d exp=1/1", terr_cnt, terr_at_drop);
    end
    n_tests++;
    if (gap != 3 || stage != 3) begin
      n_fail++; $display("FAIL timeout_regrant got=%0d exp=3", gap);
    end
    req = '0; pxv = '0;
    repeat (4) step();
  endtask

  task automatic test_abort();
    req = 4'b0010; done = '0; pxv = '0;
    for (int c = 0; c < 5 && grant !== 4'b0010; c++) step();
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++; $display("FAIL abort_grant_wait got=%b exp=0010", grant);
    end
    pxv = 4'b0010; set_px(1, 9, 3, 2);
    step();
    pxv = 4'b1000; done = 4'b1000; set_px(3, 200, 100, 7);
    step();
    n_tests++;
    if (grant !== 4'b0010 || plot !== 1'b0 || x !== 8'd9) begin
      n_fail++; $display("FAIL abort_stray got=%b,%b,%0d exp=0010,0,9", grant, plot, x);
    end
    n_tests++;
    if (act_vec !== exp_vec) begin
      n_fail++; $display("FAIL abort_model got=%h exp=%h", act_vec, exp_vec);
    end
    pxv = '0; done = '0; req = '0;
    step();
    n_tests++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_release got=%b/%b exp=0000/0", grant, busy);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    for (int c = 0; c < 5 && grant !== 4'b0100; c++) step();
    pxv = 4'b0100; set_px(2, 77, 55, 6);
    step();
    n_tests++;
    if (plot !== 1'b1 || x !== 8'd77) begin
      n_fail++; $display("FAIL resetmid_plotting got=%b,%0d exp=1,77", plot, x);
    end
    rst_n = 1'b0;
    step();
    n_tests++;
    if (act_vec !== '0) begin
      n_fail++; $display("FAIL resetmid_zero got=%h exp=0", act_vec);
    end
    rst_n = 1'b1; req = 4'b1010; pxv = '0;
    repeat (2) step();
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++; $display("FAIL resetmid_rearb got=%b exp=0010", grant);
    end
    n_tests++;
    if (act_vec !== exp_vec) begin
      n_fail++; $display("FAIL resetmid_model got=%h exp=%h", act_vec, exp_vec);
    end
    req = '0;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        done[i] = ($urandom_range(0, 7) == 0);
      end
      pxv = 4'($urandom); xin = $urandom; yin = 28'($urandom); cin = 12'($urandom);
      step();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL random_model cyc%0d got=%h exp=%h", c, act_vec, exp_vec);
      end
      n_tests++;
      if (!$onehot0(grant)) begin
        n_fail++; $display("FAIL random_onehot cyc%0d got=%b exp=onehot0", c, grant);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_phase = P_FREE; m_owner = -1; m_ptr = 0; m_held = 0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
